// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown timer.
// The FSM state enum and the default counter width live here.
package timer_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } timer_state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Control and status bundle of the countdown timer.
// The master drives the controls; the slave (the timer) drives the status.
interface countdown_timer_if #(parameter int WIDTH = 4);

   logic             enable;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             start;
   logic             stop;
   logic             periodic;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;
   logic             tc;

   modport master (
      output enable, load, load_value, start, stop, periodic,
      input  count, busy, done, tc
   );

   modport slave (
      input  enable, load, load_value, start, stop, periodic,
      output count, busy, done, tc
   );

endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot or auto-reload terminal count.
// All outputs come straight from registers, so no input reaches an output combinationally.
module countdown_timer
   import timer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                clk,
   input  logic                reset,
   countdown_timer_if.slave    bus
);

   timer_state_e     r_state;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_reload;
   logic             r_tc;

   timer_state_e     w_state_nxt;
   logic [WIDTH-1:0] w_count_nxt;
   logic [WIDTH-1:0] w_reload_nxt;
   logic             w_tc_nxt;
   logic             w_busy;
   logic             w_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_count  <= '0;
         r_reload <= '0;
         r_tc     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_reload <= w_reload_nxt;
         r_tc     <= w_tc_nxt;
      end
   end

   // Priority: load > stop > start > enable tick. A stop outside RUN still
   // blocks a same-cycle start.
   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_reload_nxt = r_reload;
      w_tc_nxt     = 1'b0;
      if (bus.load) begin
         w_count_nxt  = bus.load_value;
         w_reload_nxt = bus.load_value;
         w_state_nxt  = ST_IDLE;
      end else if (bus.stop) begin
         if (r_state == ST_RUN)
            w_state_nxt = ST_IDLE;
      end else if (bus.start) begin
         w_count_nxt = r_reload;
         w_state_nxt = ST_RUN;
      end else if (r_state == ST_RUN && bus.enable) begin
         // Expire at 1 (or 0 for a zero reload) so the counter never wraps.
         if (r_count <= WIDTH'(1)) begin
            w_tc_nxt = 1'b1;
            if (bus.periodic) begin
               w_count_nxt = r_reload;
            end else begin
               w_count_nxt = '0;
               w_state_nxt = ST_DONE;
            end
         end else begin
            w_count_nxt = r_count - WIDTH'(1);
         end
      end
   end

   always_comb begin
      w_busy = (r_state == ST_RUN);
      w_done = (r_state == ST_DONE);
   end

   assign bus.count = r_count;
   assign bus.tc    = r_tc;
   assign bus.busy  = w_busy;
   assign bus.done  = w_done;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: each task drives one scenario and checks
// {count, tc, busy, done} against hand-computed values one cycle after the edge.
module tb_countdown_timer;

   localparam int W = 4;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   countdown_timer_if #(.WIDTH(W)) bus ();

   countdown_timer #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W+2:0] snap();
      return {bus.count, bus.tc, bus.busy, bus.done};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.enable = 1'b0; bus.load = 1'b0; bus.load_value = '0;
      bus.start  = 1'b0; bus.stop = 1'b0; bus.periodic = 1'b0;
   endtask

   task automatic do_load(input logic [W-1:0] v);
      bus.load = 1'b1; bus.load_value = v;
      tick();
      bus.load = 1'b0;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      logic [W+2:0] obs, exp;
      quiet();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      obs = snap(); exp = {4'd0, 1'b0, 1'b0, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL reset: got %b want %b", obs, exp); end
   endtask

   task automatic test_oneshot();
      logic [W+2:0] obs, exp;
      logic [W-1:0] cnt [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
      do_load(4'd5);
      obs = snap(); exp = {4'd5, 1'b0, 1'b0, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL oneshot_load: got %b want %b", obs, exp); end
      do_start();
      obs = snap(); exp = {4'd5, 1'b0, 1'b1, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL oneshot_start: got %b want %b", obs, exp); end
      bus.enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         obs = snap();
         exp = (i == 4) ? {4'd0, 1'b1, 1'b0, 1'b1} : {cnt[i], 1'b0, 1'b1, 1'b0};
         total++;
         if (obs !== exp) begin bad++; $display("FAIL oneshot_step%0d: got %b want %b", i, obs, exp); end
      end
      tick();
      obs = snap(); exp = {4'd0, 1'b0, 1'b0, 1'b1};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL oneshot_hold: got %b want %b", obs, exp); end
      bus.enable = 1'b0;
   endtask

   task automatic test_periodic();
      logic [W+2:0] obs, exp;
      logic [W-1:0] cnt [9] = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
      do_load(4'd3);
      bus.periodic = 1'b1;
      do_start();
      obs = snap(); exp = {4'd3, 1'b0, 1'b1, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL periodic_start: got %b want %b", obs, exp); end
      bus.enable = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         obs = snap();
         exp = {cnt[i], (cnt[i] == 4'd3), 1'b1, 1'b0};
         total++;
         if (obs !== exp) begin bad++; $display("FAIL periodic_step%0d: got %b want %b", i, obs, exp); end
      end
      bus.enable = 1'b0; bus.periodic = 1'b0;
   endtask

   task automatic test_enable_gaps();
      logic [W+2:0] obs, exp;
      logic         en  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [W-1:0] cnt [6] = '{4'd3, 4'd3, 4'd2, 4'd2, 4'd1, 4'd0};
      do_load(4'd4);
      do_start();
      obs = snap(); exp = {4'd4, 1'b0, 1'b1, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL gaps_start: got %b want %b", obs, exp); end
      for (int i = 0; i < 6; i++) begin
         bus.enable = en[i];
         tick();
         obs = snap();
         exp = (i == 5) ? {4'd0, 1'b1, 1'b0, 1'b1} : {cnt[i], 1'b0, 1'b1, 1'b0};
         total++;
         if (obs !== exp) begin bad++; $display("FAIL gaps_step%0d: got %b want %b", i, obs, exp); end
      end
      bus.enable = 1'b0;
   endtask

   task automatic test_stop();
      logic [W+2:0] obs, exp;
      do_load(4'd9);
      do_start();
      bus.enable = 1'b1;
      tick(); tick(); tick();
      obs = snap(); exp = {4'd6, 1'b0, 1'b1, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL stop_pre: got %b want %b", obs, exp); end
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      obs = snap(); exp = {4'd6, 1'b0, 1'b0, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL stop_halt: got %b want %b", obs, exp); end
      tick();
      obs = snap();
      total++;
      if (obs !== exp) begin bad++; $display("FAIL stop_idle_enable: got %b want %b", obs, exp); end
      bus.enable = 1'b0;
      do_start();
      obs = snap(); exp = {4'd9, 1'b0, 1'b1, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL stop_restart: got %b want %b", obs, exp); end
   endtask

   task automatic test_priority_and_reset();
      logic [W+2:0] obs, exp;
      bus.enable = 1'b1;
      tick();
      bus.load = 1'b1; bus.start = 1'b1; bus.stop = 1'b1; bus.load_value = 4'd2;
      tick();
      bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
      obs = snap(); exp = {4'd2, 1'b0, 1'b0, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL load_wins: got %b want %b", obs, exp); end
      do_start();
      tick();
      obs = snap(); exp = {4'd1, 1'b0, 1'b1, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL pre_reset: got %b want %b", obs, exp); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      obs = snap(); exp = {4'd0, 1'b0, 1'b0, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL reset_mid_run: got %b want %b", obs, exp); end
      bus.enable = 1'b0;
   endtask

   task automatic test_zero_reload();
      logic [W+2:0] obs, exp;
      do_load(4'd0);
      bus.periodic = 1'b0;
      do_start();
      obs = snap(); exp = {4'd0, 1'b0, 1'b1, 1'b0};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL zero_start: got %b want %b", obs, exp); end
      bus.enable = 1'b1;
      tick();
      obs = snap(); exp = {4'd0, 1'b1, 1'b0, 1'b1};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL zero_expire: got %b want %b", obs, exp); end
      tick();
      obs = snap(); exp = {4'd0, 1'b0, 1'b0, 1'b1};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL zero_tc_once: got %b want %b", obs, exp); end
      bus.periodic = 1'b1;
      do_start();
      for (int i = 0; i < 3; i++) begin
         tick();
         obs = snap(); exp = {4'd0, 1'b1, 1'b1, 1'b0};
         total++;
         if (obs !== exp) begin bad++; $display("FAIL zero_periodic%0d: got %b want %b", i, obs, exp); end
      end
      bus.enable = 1'b0; bus.periodic = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      quiet();
      test_reset();
      test_oneshot();
      test_periodic();
      test_enable_gaps();
      test_stop();
      test_priority_and_reset();
      test_zero_reload();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
